// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller feeding a 1:8 demux full-adder stage, LSB first.
// Latency: done pulses WIDTH+1 edges after the accepting start edge; one add per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE, ignored (not queued) while busy. Option: SIGNED_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             fa_I,
    output logic [2:0]       fa_s,
    input  logic             fa_sum,
    input  logic             fa_carry
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        fa_I    = 1'b0;
        fa_s    = 3'b000;
        case (state_q)
            IDLE: begin
                if (start) state_d = ADD;
            end
            ADD: begin
                busy = 1'b1;
                fa_I = 1'b1;
                fa_s = {a_sh[0], b_sh[0], carry_q};
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operands shift out LSB first, returned sum bits shift in from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else if (state_q == IDLE && start) begin
            a_sh     <= a;
            b_sh     <= b;
            carry_q  <= cin;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (state_q == ADD) begin
            result_q <= {fa_sum, result_q[WIDTH-1:1]};
            carry_q  <= fa_carry;
            a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LAST) cout_q <= fa_carry;
        end
    end

`ifdef SIGNED_OVF_EN
    logic ovf_q;

    // Carry into the MSB (carry_q) differing from carry out of it flags signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            ovf_q <= 1'b0;
        end else if (state_q == ADD && cnt_q == LAST) begin
            ovf_q <= carry_q ^ fa_carry;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign result = result_q;
    assign cout   = cout_q;

endmodule
